setting_state_controller: RTL and testbench

//  Front-end control stage of the egg timer, directly upstream of the countdown stage.
//  - Accepts debounced keypad events and builds the MM:SS setting as four BCD digits.
//  - Runs the IDLE/SETTING/RUNNING/STOPPED/ALARM state machine.
//  - Drives the isSetting/isStarting/isStopping/isRunning controls to the countdown stage.
//  - Consumes that stage's isZero flag and raises a timed, blinking alarm.

---
 rtl/setting_state_controller.sv | 155 +++++++++++++++
 tb/tb_setting_state_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/setting_state_controller.sv
// Egg-timer front end: builds the MM:SS setting from keypad events, sequences
// IDLE/SETTING/RUNNING/STOPPED/ALARM and drives the countdown-stage controls.
module setting_state_controller #(
  parameter int ALARM_CYCLES = 250000000,
  parameter int BLINK_CYCLES = 12500000,
  parameter int ZERO_GUARD   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  input  logic       isZero,
  output logic [3:0] setting0,
  output logic [3:0] setting1,
  output logic [3:0] setting2,
  output logic [3:0] setting3,
  output logic       isSetting,
  output logic       isStarting,
  output logic       isStopping,
  output logic       isRunning,
  output logic       alarm
);

  localparam int AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int GW = (ZERO_GUARD > 0) ? $clog2(ZERO_GUARD + 1) : 1;
  localparam logic [AW-1:0] ALARM_LOAD = AW'(ALARM_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);
  localparam logic [GW-1:0] GUARD_LOAD = GW'(ZERO_GUARD);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTING, S_RUNNING, S_STOPPED, S_ALARM
  } state_t;

  state_t        state, state_nx;
  logic [3:0]    s0_nx, s1_nx, s2_nx, s3_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic [AW-1:0] acnt, acnt_nx;
  logic [BW-1:0] bcnt, bcnt_nx;
  logic          alarm_nx, starting_nx, stopping_nx;
  logic          key_digit, key_clear, key_ss, set_nonzero;

  assign key_digit   = keyValid && (keyCode <= 4'd9);
  assign key_clear   = keyValid && (keyCode == 4'hA);
  assign key_ss      = keyValid && (keyCode == 4'hB);
  assign set_nonzero = |{setting3, setting2, setting1, setting0};

  always_comb begin
    state_nx    = state;
    s0_nx       = setting0;
    s1_nx       = setting1;
    s2_nx       = setting2;
    s3_nx       = setting3;
    gcnt_nx     = gcnt;
    acnt_nx     = acnt;
    bcnt_nx     = bcnt;
    alarm_nx    = 1'b0;
    starting_nx = 1'b0;
    stopping_nx = 1'b0;
    case (state)
      S_IDLE, S_SETTING: begin
        // A seconds-ones digit above 5 cannot become a valid seconds-tens digit.
        if (key_digit && (setting0 <= 4'd5)) begin
          s3_nx    = setting2;
          s2_nx    = setting1;
          s1_nx    = setting0;
          s0_nx    = keyCode;
          state_nx = S_SETTING;
        end else if (key_clear) begin
          {s3_nx, s2_nx, s1_nx, s0_nx} = '0;
          state_nx = S_IDLE;
        end else if (key_ss && set_nonzero) begin
          state_nx    = S_RUNNING;
          starting_nx = 1'b1;
          gcnt_nx     = GUARD_LOAD;
        end
      end
      S_RUNNING: begin
        // isZero lags the countdown load, so it is ignored until the guard expires.
        if ((gcnt == '0) && isZero) begin
          state_nx = S_ALARM;
          acnt_nx  = ALARM_LOAD;
          bcnt_nx  = BLINK_LOAD;
          alarm_nx = 1'b1;
        end else begin
          if (gcnt != '0) gcnt_nx = gcnt - GW'(1);
          if (key_clear) begin
            {s3_nx, s2_nx, s1_nx, s0_nx} = '0;
            state_nx = S_IDLE;
          end else if (key_ss) begin
            state_nx    = S_STOPPED;
            stopping_nx = 1'b1;
          end
        end
      end
      S_STOPPED: begin
        if (key_clear) begin
          {s3_nx, s2_nx, s1_nx, s0_nx} = '0;
          state_nx = S_IDLE;
        end else if (key_ss) begin
          state_nx = S_RUNNING;
          gcnt_nx  = GUARD_LOAD;
        end
      end
      S_ALARM: begin
        if (keyValid || (acnt == '0)) begin
          state_nx = S_IDLE;
        end else begin
          acnt_nx = acnt - AW'(1);
          if (bcnt == '0) begin
            alarm_nx = ~alarm;
            bcnt_nx  = BLINK_LOAD;
          end else begin
            alarm_nx = alarm;
            bcnt_nx  = bcnt - BW'(1);
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      setting0   <= '0;
      setting1   <= '0;
      setting2   <= '0;
      setting3   <= '0;
      gcnt       <= '0;
      acnt       <= '0;
      bcnt       <= '0;
      isSetting  <= 1'b1;
      isStarting <= 1'b0;
      isStopping <= 1'b0;
      isRunning  <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_nx;
      setting0   <= s0_nx;
      setting1   <= s1_nx;
      setting2   <= s2_nx;
      setting3   <= s3_nx;
      gcnt       <= gcnt_nx;
      acnt       <= acnt_nx;
      bcnt       <= bcnt_nx;
      isSetting  <= (state_nx == S_IDLE) || (state_nx == S_SETTING);
      isStarting <= starting_nx;
      isStopping <= stopping_nx;
      isRunning  <= (state_nx == S_RUNNING);
      alarm      <= alarm_nx;
    end
  end

endmodule

// File: tb/tb_setting_state_controller.sv
// Bench for setting_state_controller: directed scenarios plus random keypad
// traffic, all outputs compared every cycle against a behavioural model.
module tb_setting_state_controller;

  localparam int AC = 20;
  localparam int BC = 3;
  localparam int ZG = 2;

  localparam int M_IDLE = 0, M_SET = 1, M_RUN = 2, M_STOP = 3, M_ALARM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       keyValid = 1'b0;
  logic [3:0] keyCode = 4'h0;
  logic       isZero = 1'b0;
  logic [3:0] setting0, setting1, setting2, setting3;
  logic       isSetting, isStarting, isStopping, isRunning, alarm;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: mode, digits (index 0 = seconds ones), time in RUNNING / ALARM.
  int m_mode = M_IDLE;
  int m_d[4] = '{0, 0, 0, 0};
  int m_rt = 0;
  int m_at = 0;
  bit m_start = 0;
  bit m_stop = 0;

  setting_state_controller #(
    .ALARM_CYCLES(AC),
    .BLINK_CYCLES(BC),
    .ZERO_GUARD  (ZG)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .keyValid  (keyValid),
    .keyCode   (keyCode),
    .isZero    (isZero),
    .setting0  (setting0),
    .setting1  (setting1),
    .setting2  (setting2),
    .setting3  (setting3),
    .isSetting (isSetting),
    .isStarting(isStarting),
    .isStopping(isStopping),
    .isRunning (isRunning),
    .alarm     (alarm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_digits();
    for (int i = 0; i < 4; i++) m_d[i] = 0;
  endtask

  task automatic model_step(input bit r, input bit kv, input int kc, input bit z);
    m_start = 0;
    m_stop  = 0;
    if (r) begin
      m_mode = M_IDLE;
      clear_digits();
      return;
    end
    case (m_mode)
      M_IDLE, M_SET: if (kv) begin
        if (kc <= 9) begin
          if (m_d[0] <= 5) begin
            m_d[3] = m_d[2]; m_d[2] = m_d[1]; m_d[1] = m_d[0]; m_d[0] = kc;
            m_mode = M_SET;
          end
        end else if (kc == 10) begin
          clear_digits();
          m_mode = M_IDLE;
        end else if (kc == 11 && (m_d[0] + m_d[1] + m_d[2] + m_d[3]) != 0) begin
          m_mode = M_RUN; m_rt = 0; m_start = 1;
        end
      end
      M_RUN: begin
        if (z && m_rt >= ZG) begin
          m_mode = M_ALARM; m_at = 0;
        end else begin
          m_rt++;
          if (kv && kc == 10) begin
            clear_digits();
            m_mode = M_IDLE;
          end else if (kv && kc == 11) begin
            m_mode = M_STOP; m_stop = 1;
          end
        end
      end
      M_STOP: if (kv && kc == 10) begin
        clear_digits();
        m_mode = M_IDLE;
      end else if (kv && kc == 11) begin
        m_mode = M_RUN; m_rt = 0;
      end
      M_ALARM: if (kv || m_at == AC - 1) m_mode = M_IDLE;
               else m_at++;
      default: m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [15:0] exp_set();
    return {4'(m_d[3]), 4'(m_d[2]), 4'(m_d[1]), 4'(m_d[0])};
  endfunction

  function automatic logic [4:0] exp_ctrl();
    logic blink;
    blink = (m_mode == M_ALARM) && (((m_at / BC) % 2) == 0);
    return {m_mode == M_IDLE || m_mode == M_SET, m_start, m_stop, m_mode == M_RUN, blink};
  endfunction

  task automatic cycle(input logic r, input logic kv, input logic [3:0] kc, input logic z);
    reset = r; keyValid = kv; keyCode = kc; isZero = z;
    @(posedge clk);
    model_step(r, kv, int'(kc), z);
    #1;
    chk("settings", 32'({setting3, setting2, setting1, setting0}), 32'(exp_set()));
    chk("ctrl", 32'({isSetting, isStarting, isStopping, isRunning, alarm}), 32'(exp_ctrl()));
  endtask

  task automatic key(input logic [3:0] k);
    cycle(1'b0, 1'b1, k, 1'b0);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  initial begin
    int n;
    cycle(1'b1, 1'b1, 4'h5, 1'b0);
    cycle(1'b1, 1'b0, 4'h0, 1'b0);
    chk("reset_set", 32'({setting3, setting2, setting1, setting0}), 32'h0);
    chk("reset_ctrl", 32'({isSetting, isStarting, isStopping, isRunning, alarm}), 32'b10000);

    // Digit entry and rejected shift.
    key(4'h1); key(4'h3); key(4'h0);
    chk("t1_set", 32'({setting3, setting2, setting1, setting0}), 32'h0130);
    chk("t1_issetting", 32'(isSetting), 32'h1);
    key(4'h9); key(4'h0);
    chk("t2_reject", 32'({setting3, setting2, setting1, setting0}), 32'h1309);

    // Start / stop / resume.
    key(4'hA); key(4'h0); key(4'h5);
    chk("t3_set", 32'({setting3, setting2, setting1, setting0}), 32'h0005);
    key(4'hB);
    chk("t3_start", 32'({isStarting, isRunning}), 32'b11);
    idle();
    chk("t3_start_pulse", 32'(isStarting), 32'h0);
    key(4'hB);
    chk("t3_stop", 32'({isStopping, isRunning}), 32'b10);
    key(4'hB);
    chk("t3_resume", 32'({isStarting, isRunning}), 32'b01);

    // Guarded isZero, then alarm blink and timed return.
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t4_guard", 32'(isRunning), 32'h1);
    cycle(1'b0, 1'b0, 4'h0, 1'b1);
    chk("t4_alarm_on", 32'({isRunning, alarm}), 32'b01);
    n = 1;
    while (!isSetting && n < 100) begin
      idle();
      if (!isSetting) begin
        n++;
        if (n == BC + 1) chk("t4_blink_low", 32'(alarm), 32'h0);
        if (n == 2 * BC + 1) chk("t4_blink_high", 32'(alarm), 32'h1);
      end
    end
    chk("t4_alarm_len", 32'(n), 32'(AC));
    chk("t4_retained", 32'({setting3, setting2, setting1, setting0, 3'b000, alarm}), 32'h00050);

    // isZero beats a simultaneous key; a key ends the alarm.
    key(4'hB); idle(); idle();
    cycle(1'b0, 1'b1, 4'hB, 1'b1);
    chk("t5_zero_wins", 32'({isStopping, alarm}), 32'b01);
    key(4'h7);
    chk("t5_key_exit", 32'({isSetting, alarm}), 32'b10);
    chk("t5_keep_set", 32'({setting3, setting2, setting1, setting0}), 32'h0005);

    // Start with zero setting is ignored; reset mid-run.
    key(4'hA); key(4'hB);
    chk("t6_zero_start", 32'({isStarting, isRunning}), 32'b00);
    key(4'h1); key(4'hB); idle();
    cycle(1'b1, 1'b1, 4'h3, 1'b0);
    chk("t6_reset_set", 32'({setting3, setting2, setting1, setting0}), 32'h0);
    chk("t6_reset_ctrl", 32'({isSetting, isStarting, isStopping, isRunning, alarm}), 32'b10000);

    // Random keypad traffic.
    for (int i = 0; i < 3000; i++) begin
      logic       r, kv, z;
      logic [3:0] kc;
      int         pick;
      r  = ($urandom_range(0, 249) == 0);
      kv = ($urandom_range(0, 2) == 0);
      pick = $urandom_range(0, 19);
      if (pick < 11)      kc = 4'($urandom_range(0, 9));
      else if (pick < 13) kc = 4'hA;
      else if (pick < 18) kc = 4'hB;
      else                kc = 4'($urandom_range(12, 15));
      z = ($urandom_range(0, 9) == 0);
      cycle(r, kv, kc, z);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
